// File: rtl/regfile_2w_if.sv
// Bus bundle for the two-write / two-read register file.
// The master drives write ports and read addresses; the slave returns read data and valid flags.
interface regfile_2w_if #(
  parameter int WIDTH = 64,
  parameter int AW    = 5
);
  logic             en0;
  logic [AW-1:0]    RW0;
  logic [WIDTH-1:0] data0;
  logic             en1;
  logic [AW-1:0]    RW1;
  logic [WIDTH-1:0] data1;
  logic [AW-1:0]    RA;
  logic [AW-1:0]    RB;
  logic [WIDTH-1:0] DRA;
  logic [WIDTH-1:0] DRB;
  logic             VA;
  logic             VB;

  modport master (
    output en0, RW0, data0, en1, RW1, data1, RA, RB,
    input  DRA, DRB, VA, VB
  );

  modport slave (
    input  en0, RW0, data0, en1, RW1, data1, RA, RB,
    output DRA, DRB, VA, VB
  );
endinterface

// File: rtl/regfile_2w.sv
// Register file with two write ports, two combinational read ports, per-register valid bits,
// an optional hardwired-zero register and optional same-cycle write-to-read forwarding.
module regfile_2w #(
  parameter int WIDTH    = 64,
  parameter int AW       = 5,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_REG = (1 << AW) - 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_2w_if.slave  bus
);
  localparam int            DEPTH     = 1 << AW;
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);
  localparam bit            ZERO_ON   = (ZERO_EN != 0);
  localparam bit            BYPASS_ON = (BYPASS != 0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;

  logic             we0_s;
  logic             we1_s;
  logic [AW-1:0]    raddr_s [2];
  logic [WIDTH-1:0] rdata_s [2];
  logic             rvld_s  [2];

  // Qualified write enables: writes to the zero register and writes under reset never take effect.
  always_comb begin
    we0_s = bus.en0 & rst_n & ~(ZERO_ON & (bus.RW0 == ZERO_ADDR));
    we1_s = bus.en1 & rst_n & ~(ZERO_ON & (bus.RW1 == ZERO_ADDR));
  end

  // Next-state storage; port 1 wins an address collision.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we1_s && (bus.RW1 == AW'(i))) begin
        mem_d[i] = bus.data1;
        vld_d[i] = 1'b1;
      end else if (we0_s && (bus.RW0 == AW'(i))) begin
        mem_d[i] = bus.data0;
        vld_d[i] = 1'b1;
      end else begin
        mem_d[i] = mem_q[i];
        vld_d[i] = vld_q[i];
      end
    end
  end

  // Storage and valid-bit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      vld_q <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      vld_q <= vld_d;
    end
  end

  assign raddr_s[0] = bus.RA;
  assign raddr_s[1] = bus.RB;

  // Read ports: zero register first (valid even in reset), then reset blanking, then forwarding.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata_s[p] = {WIDTH{1'b0}};
      rvld_s[p]  = 1'b0;
      if (ZERO_ON && (raddr_s[p] == ZERO_ADDR)) begin
        rdata_s[p] = {WIDTH{1'b0}};
        rvld_s[p]  = 1'b1;
      end else if (!rst_n) begin
        rdata_s[p] = {WIDTH{1'b0}};
        rvld_s[p]  = 1'b0;
      end else if (BYPASS_ON && we1_s && (bus.RW1 == raddr_s[p])) begin
        rdata_s[p] = bus.data1;
        rvld_s[p]  = 1'b1;
      end else if (BYPASS_ON && we0_s && (bus.RW0 == raddr_s[p])) begin
        rdata_s[p] = bus.data0;
        rvld_s[p]  = 1'b1;
      end else begin
        rdata_s[p] = mem_q[raddr_s[p]];
        rvld_s[p]  = vld_q[raddr_s[p]];
      end
    end
  end

  assign bus.DRA = rdata_s[0];
  assign bus.VA  = rvld_s[0];
  assign bus.DRB = rdata_s[1];
  assign bus.VB  = rvld_s[1];
endmodule

// File: tb/tb_regfile_2w.sv
// Randomized scoreboard bench: a forwarding and a non-forwarding instance share stimulus and are
// compared against an array-based reference model.
module tb_regfile_2w;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en0, en1;
  logic [4:0]  rw0, rw1, ra, rb;
  logic [63:0] d0, d1;

  always #5 clk = ~clk;

  regfile_2w_if #(.WIDTH(64), .AW(5)) bus_bp ();
  regfile_2w_if #(.WIDTH(64), .AW(5)) bus_nb ();

  assign bus_bp.en0 = en0;  assign bus_nb.en0 = en0;
  assign bus_bp.RW0 = rw0;  assign bus_nb.RW0 = rw0;
  assign bus_bp.data0 = d0; assign bus_nb.data0 = d0;
  assign bus_bp.en1 = en1;  assign bus_nb.en1 = en1;
  assign bus_bp.RW1 = rw1;  assign bus_nb.RW1 = rw1;
  assign bus_bp.data1 = d1; assign bus_nb.data1 = d1;
  assign bus_bp.RA = ra;    assign bus_nb.RA = ra;
  assign bus_bp.RB = rb;    assign bus_nb.RB = rb;

  regfile_2w #(.WIDTH(64), .AW(5), .ZERO_EN(1), .ZERO_REG(31), .BYPASS(1)) u_bp (
    .clk(clk), .rst_n(rst_n), .bus(bus_bp)
  );
  regfile_2w #(.WIDTH(64), .AW(5), .ZERO_EN(1), .ZERO_REG(31), .BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .bus(bus_nb)
  );

  // Reference model: plain arrays of register contents and written-since-reset flags.
  logic [63:0] m_mem [32];
  bit          m_vld [32];

  typedef struct {
    string       nm;
    logic [64:0] a_bp, b_bp, a_nb, b_nb;
  } exp_t;
  exp_t sb[$];

  int n_total = 0;
  int n_pass  = 0;

  function automatic logic [64:0] model_rd(input logic [4:0] a, input bit bp);
    if (a == 5'd31) return {1'b1, 64'd0};
    if (rst_n !== 1'b1) return {1'b0, 64'd0};
    if (bp && en1 && rw1 == a && rw1 != 5'd31) return {1'b1, d1};
    if (bp && en0 && rw0 == a && rw0 != 5'd31) return {1'b1, d0};
    return {m_vld[a], m_mem[a]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 64'd0;
      m_vld[i] = 1'b0;
    end
  endtask

  task automatic model_commit();
    if (rst_n === 1'b1) begin
      if (en0 && rw0 != 5'd31) begin m_mem[rw0] = d0; m_vld[rw0] = 1'b1; end
      if (en1 && rw1 != 5'd31) begin m_mem[rw1] = d1; m_vld[rw1] = 1'b1; end
    end
  endtask

  task automatic step(input string nm);
    exp_t e;
    e.nm   = nm;
    e.a_bp = model_rd(ra, 1'b1);
    e.b_bp = model_rd(rb, 1'b1);
    e.a_nb = model_rd(ra, 1'b0);
    e.b_nb = model_rd(rb, 1'b0);
    sb.push_back(e);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_wr(input logic e0, input logic [4:0] a0, input logic [63:0] v0,
                        input logic e1, input logic [4:0] a1, input logic [63:0] v1);
    en0 = e0; rw0 = a0; d0 = v0;
    en1 = e1; rw1 = a1; d1 = v1;
  endtask

  task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got valid=%0b data=%h, expected valid=%0b data=%h",
                  nm, act[64], act[63:0], exp[64], exp[63:0]);
  endtask

  // Monitor: outputs are combinational, so every queued expectation is settled by the falling edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.nm, "/bp/A"}, {bus_bp.VA, bus_bp.DRA}, e.a_bp);
      check({e.nm, "/bp/B"}, {bus_bp.VB, bus_bp.DRB}, e.b_bp);
      check({e.nm, "/nb/A"}, {bus_nb.VA, bus_nb.DRA}, e.a_nb);
      check({e.nm, "/nb/B"}, {bus_nb.VB, bus_nb.DRB}, e.b_nb);
    end
  end

  task automatic read_all(input string nm);
    set_wr(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i - 1);
      rb = 5'(i);
      step(nm);
    end
  endtask

  initial begin
    logic [63:0] pat;
    rst_n = 1'b0;
    model_clear();
    set_wr(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    ra = 5'd31; rb = 5'd0;
    @(posedge clk); #1;

    step("reset_idle");
    set_wr(1'b1, 5'd3, 64'h1234, 1'b1, 5'd4, 64'h5678);
    ra = 5'd4; rb = 5'd3;
    step("reset_wr_ignored");
    set_wr(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    step("reset_after");

    rst_n = 1'b1;
    set_wr(1'b1, 5'd31, 64'hA0, 1'b0, 5'd0, 64'd0);
    ra = 5'd31; rb = 5'd3;
    step("zero_wr");
    set_wr(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    step("zero_rd");

    for (int i = 0; i < 31; i++) begin
      pat = 64'(i) * 64'h0000010204080001;
      if (i % 2 == 0) set_wr(1'b1, 5'(i), pat, 1'b0, 5'($urandom_range(0, 31)), {$urandom, $urandom});
      else            set_wr(1'b0, 5'($urandom_range(0, 31)), {$urandom, $urandom}, 1'b1, 5'(i), pat);
      ra = 5'(i);
      rb = 5'($urandom_range(0, 31));
      step("pattern_wr");
    end
    read_all("pattern_rd");

    for (int c = 0; c < 10; c++) begin
      set_wr(1'b0, 5'($urandom_range(0, 31)), {$urandom, $urandom},
             1'b0, 5'($urandom_range(0, 31)), {$urandom, $urandom});
      ra = 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      step("disabled_wr");
    end
    read_all("disabled_rd");

    set_wr(1'b1, 5'd5, 64'h11, 1'b1, 5'd5, 64'h22);
    ra = 5'd5; rb = 5'd5;
    step("collide_wr");
    set_wr(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    step("collide_rd");

    set_wr(1'b1, 5'd9, 64'hBEEF, 1'b1, 5'd7, 64'hDEAD);
    ra = 5'd7; rb = 5'd9;
    step("bypass_wr");
    set_wr(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    step("bypass_rd");

    for (int c = 0; c < 300; c++) begin
      set_wr(1'($urandom), 5'($urandom_range(0, 31)), {$urandom, $urandom},
             1'($urandom), 5'($urandom_range(0, 31)), {$urandom, $urandom});
      if (c % 3 == 0) begin
        rw0 = 5'($urandom_range(0, 3));
        rw1 = 5'($urandom_range(0, 3));
        ra  = 5'($urandom_range(0, 3));
        rb  = 5'($urandom_range(0, 3));
      end else begin
        ra = 5'($urandom_range(0, 31));
        rb = 5'($urandom_range(0, 31));
      end
      step("random");
    end

    for (int i = 0; i < 4; i++) begin
      set_wr(1'b1, 5'(i), 64'hFF, 1'b0, 5'd0, 64'd0);
      ra = 5'(i); rb = 5'd30;
      step("fill_ff");
    end
    set_wr(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    ra = 5'd0; rb = 5'd3;
    step("fill_ff_rd");
    #2;
    rst_n = 1'b0;
    model_clear();
    set_wr(1'b1, 5'd2, 64'h55, 1'b1, 5'd3, 64'h66);
    ra = 5'd0; rb = 5'd1;
    step("midreset");
    rst_n = 1'b1;
    set_wr(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    ra = 5'd2; rb = 5'd3;
    step("midreset_after");
    read_all("final_rd");

    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
